frame_capture: RTL
==================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Parameter H_WORDS, default 160, meaning data words per stored line (640 raw8 pixels / 4).
REQ-002 Parameter V_LINES, default 480, meaning stored lines per frame.
REQ-003 Parameter DATA_WIDTH, default 32, meaning width of the image word and the buffer write word.
REQ-004 Parameter ADDR_WIDTH, default 17, meaning buffer word-address width, which SHALL be at least ceil(log2(H_WORDS*V_LINES)).
REQ-005 Parameter SKIP_FRAMES, default 2, meaning complete frames discarded after arm before storing.
REQ-006 Ports: clk  in  1  single clock (pixel clock domain); reset  in  1  asynchronous, active-high.
REQ-007 Ports: arm  in  1  start-capture pulse; abort  in  1  return-to-idle pulse; continuous  in  1  level, 1 = recapture every frame.
REQ-008 Ports: image_data  in  DATA_WIDTH  packet payload word; image_data_enable  in  1  one word valid per high cycle.
REQ-009 Ports: frame_start, frame_end, line_end  in  1 each  single-cycle CSI-2 short-packet strobes.
REQ-010 Ports: wr_en  out  1; wr_addr  out  ADDR_WIDTH; wr_data  out  DATA_WIDTH  buffer write port.
REQ-011 Ports: busy  out  1; done  out  1  one-cycle pulse; frame_count  out  16  frames stored since arm.
REQ-012 Ports: overflow  out  1  sticky; short_line  out  1  sticky; frame_err  out  1  sticky.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_SOF, SKIP, CAPTURE, and DONE.
- IDLE --arm--> WAIT_SOF, clearing frame_count, all sticky flags, and the skip counter.
- WAIT_SOF --frame_start--> SKIP when the skip count is below SKIP_FRAMES, else CAPTURE.
- SKIP --frame_end--> WAIT_SOF, skip count incremented.
- CAPTURE --frame_end--> WAIT_SOF if continuous is high, else DONE.
- DONE --> IDLE after exactly one cycle.
REQ-014 busy SHALL be high in every state except IDLE.
REQ-015 arm while busy SHALL be ignored.
REQ-016 abort in any state SHALL go to IDLE next cycle, with no done pulse and no further writes.
REQ-017 abort SHALL take priority over every other event.
REQ-018 In CAPTURE, each cycle with image_data_enable high SHALL produce wr_en high on the next cycle.
- wr_data SHALL equal the sampled image_data.
- wr_addr SHALL equal line_base + col.
- Latency is exactly 1 cycle.
REQ-019 col SHALL increment per accepted word.
REQ-020 line_end SHALL advance line_base by H_WORDS, reset col to 0, and increment the line index.
REQ-021 wr_addr SHALL be formed with adders only; no multiplier is permitted.
REQ-022 line_base and col SHALL be zeroed on entering CAPTURE.
REQ-023 A word arriving when col >= H_WORDS SHALL not be written, and overflow SHALL be set.
REQ-024 A word arriving when the line index >= V_LINES SHALL not be written, and overflow SHALL be set.
REQ-025 line_end with 0 < col < H_WORDS SHALL set short_line; line_base SHALL still advance by H_WORDS.
REQ-026 line_end with col == 0 (no words since the last line_end) SHALL be ignored.
REQ-027 image_data_enable and line_end in the same cycle: the word SHALL be written at the current col, then the line SHALL advance.
REQ-028 image_data_enable and frame_end in the same cycle: the word SHALL be written, then the state SHALL transition.
REQ-029 frame_start while in CAPTURE (frame_end missing) SHALL set frame_err and restart CAPTURE with line_base, col, and the line index at 0.
REQ-030 frame_start while in SKIP SHALL set frame_err and restart the current skip frame.
REQ-031 frame_end in CAPTURE SHALL increment frame_count, saturating at 16'hFFFF, and pulse done for one cycle.
REQ-032 The done pulse of REQ-031 SHALL occur in continuous mode as well as single-shot mode.
REQ-033 continuous deasserted mid-frame SHALL let the current frame complete, then go to DONE.
REQ-034 wr_en SHALL never be high outside a cycle following an accepted CAPTURE word.

Reset
REQ-035 reset SHALL asynchronously force state IDLE and set wr_en, done, and busy to 0.
REQ-036 reset SHALL asynchronously set wr_addr, wr_data, frame_count, and all counters to 0.
REQ-037 reset SHALL asynchronously clear overflow, short_line, and frame_err.
REQ-038 reset asserted mid-capture SHALL suppress any pending write; the first wr_en SHALL occur only after a new arm.

Verification
Test parameters: H_WORDS=4, V_LINES=3, SKIP_FRAMES=1.
REQ-039 Single-shot: arm, then two full 4x3 frames.
- Frame 1 produces no wr_en.
- Frame 2 writes addresses 0..11 in order with matching data.
- done pulses once; frame_count=1; busy then falls.
REQ-040 Continuous: arm with continuous=1 and three frames.
- Frames 2 and 3 each write 0..11.
- done pulses twice; frame_count=2.
- Drop continuous during frame 3: frame 3 completes, then IDLE.
REQ-041 Errors:
- A line of 6 words writes only 4 and sets overflow.
- A line of 2 words sets short_line; the next line starts at the next 4-word line base (e.g. address 8 for line index 2).
- A 4th line sets overflow with no write.
REQ-042 frame_start issued in CAPTURE after 5 words sets frame_err; the next word is written at address 0.
REQ-043 Collisions and interrupts:
- image_data_enable coincident with line_end writes at col 3, then the next word goes to line_base+0.
- abort mid-frame gives no done and no further wr_en.
- reset mid-frame forces all outputs to 0 immediately.

Source files
------------

// File: rtl/frame_capture.sv
// Stores CSI-2 image payload words into a line-addressed frame buffer after skipping
// a configurable number of whole frames, with sticky overflow/short-line/framing flags.
module frame_capture #(
  parameter int unsigned H_WORDS     = 160,
  parameter int unsigned V_LINES     = 480,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [DATA_WIDTH-1:0] image_data,
  input  logic                  image_data_enable,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  line_end,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count,
  output logic                  overflow,
  output logic                  short_line,
  output logic                  frame_err
);

  localparam int unsigned ColW  = $clog2(H_WORDS + 1);
  localparam int unsigned LineW = $clog2(V_LINES + 1);
  localparam int unsigned SkipW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

  localparam logic [ColW-1:0]       ColMax   = ColW'(H_WORDS);
  localparam logic [LineW-1:0]      LineMax  = LineW'(V_LINES);
  localparam logic [SkipW-1:0]      SkipMax  = SkipW'(SKIP_FRAMES);
  localparam logic [ADDR_WIDTH-1:0] LineStep = ADDR_WIDTH'(H_WORDS);

  typedef enum logic [2:0] {StIdle, StWaitSof, StSkip, StCapture, StDone} state_e;

  state_e                  state_q, state_d;
  logic [SkipW-1:0]        skip_q, skip_d;
  logic [ColW-1:0]         col_q, col_d;
  logic [LineW-1:0]        line_q, line_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic [15:0]             count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    short_q, short_d;
  logic                    ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    col_d     = col_q;
    line_d    = line_q;
    base_d    = base_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    count_d   = count_q;
    ovf_d     = ovf_q;
    short_d   = short_q;
    ferr_d    = ferr_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_d = StWaitSof;
            count_d = '0;
            ovf_d   = 1'b0;
            short_d = 1'b0;
            ferr_d  = 1'b0;
            skip_d  = '0;
          end
        end
        StWaitSof: begin
          if (frame_start) begin
            if (skip_q < SkipMax) begin
              state_d = StSkip;
            end else begin
              state_d = StCapture;
              col_d   = '0;
              line_d  = '0;
              base_d  = '0;
            end
          end
        end
        StSkip: begin
          if (frame_start) begin
            ferr_d = 1'b1;
          end else if (frame_end) begin
            skip_d  = skip_q + 1'b1;
            state_d = StWaitSof;
          end
        end
        StCapture: begin
          if (frame_start) begin
            ferr_d = 1'b1;
            col_d  = '0;
            line_d = '0;
            base_d = '0;
          end else begin
            if (image_data_enable) begin
              if (col_q < ColMax && line_q < LineMax) begin
                wr_en_d   = 1'b1;
                wr_addr_d = base_q + ADDR_WIDTH'(col_q);
                wr_data_d = image_data;
                col_d     = col_q + 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            // col_d already includes a word accepted this cycle
            if (line_end && col_d != '0 && line_q < LineMax) begin
              if (col_d < ColMax) short_d = 1'b1;
              base_d = base_q + LineStep;
              col_d  = '0;
              line_d = line_q + 1'b1;
            end
            if (frame_end) begin
              if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
              done_d  = 1'b1;
              state_d = continuous ? StWaitSof : StDone;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      skip_q    <= '0;
      col_q     <= '0;
      line_q    <= '0;
      base_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      col_q     <= col_d;
      line_q    <= line_d;
      base_q    <= base_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      short_q   <= short_d;
      ferr_q    <= ferr_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign frame_count = count_q;
  assign overflow    = ovf_q;
  assign short_line  = short_q;
  assign frame_err   = ferr_q;

endmodule
